song_recorder: RTL and testbench

- Captures live playing from the 7 note keys and turns it into a stream of packed note records written to the song RAM, one record per note or rest.
- Writer end of the song-storage interface. The playback and study modes read the same 7-bit record format back out.
- Instantiated beside the free-play path; the controller drives en/start/stop. Write port connects to the song RAM write side.

---
 rtl/song_recorder_pkg.sv | 55 +++++
 rtl/song_recorder_ms_ticker.sv | 32 +++
 rtl/song_recorder.sv | 187 ++++++++++++++++++
 tb/tb_song_recorder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_recorder_pkg.sv
// Shared record layout, state encoding and helpers for the song recorder.
// Records are {octave[1:0], note[2:0], len[1:0]}; note 0 marks a rest.
package song_recorder_pkg;

   localparam int REC_W = 7;
   localparam int MS_W  = 12;

   localparam logic [2:0] NOTE_REST = 3'd0;
   localparam logic [1:0] OCT_LOW   = 2'd0;
   localparam logic [1:0] OCT_MID   = 2'd1;
   localparam logic [1:0] OCT_HIGH  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_KEY,
      S_HOLD,
      S_COMMIT,
      S_DONE
   } state_t;

   function automatic logic [REC_W-1:0] pack_rec(
      input logic [1:0] oct,
      input logic [2:0] note,
      input logic [1:0] len
   );
      return {oct, note, len};
   endfunction

   function automatic logic [1:0] len_code(
      input logic [MS_W-1:0] d,
      input logic [MS_W-1:0] t1,
      input logic [MS_W-1:0] t2,
      input logic [MS_W-1:0] t3
   );
      if (d < t1)      return 2'd0;
      else if (d < t2) return 2'd1;
      else if (d < t3) return 2'd2;
      else             return 2'd3;
   endfunction

   // Only a single pressed key is a note; release and chords give 0.
   function automatic logic [2:0] key_note(input logic [6:0] k);
      case (k)
         7'b0000001: return 3'd1;
         7'b0000010: return 3'd2;
         7'b0000100: return 3'd3;
         7'b0001000: return 3'd4;
         7'b0010000: return 3'd5;
         7'b0100000: return 3'd6;
         7'b1000000: return 3'd7;
         default:    return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/song_recorder_ms_ticker.sv
// Millisecond timebase: cycle prescaler feeding a saturating 12-bit ms counter.
// A synchronous clear restarts both so each measured interval starts at 0.
module ms_ticker #(
   parameter int TICK_CYCLES = 100000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   output logic [11:0] o_ms
);

   localparam int PW = $clog2(TICK_CYCLES + 1);
   localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

   logic [PW-1:0] r_pre;
   logic [11:0]   r_ms;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_pre <= '0;
         r_ms  <= '0;
      end else if (r_pre == LAST) begin
         r_pre <= '0;
         if (r_ms != 12'hFFF) r_ms <= r_ms + 12'd1;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   assign o_ms = r_ms;

endmodule

// File: rtl/song_recorder.sv
// Captures note-key playing as packed 7-bit records written to the song RAM.
// One record per note or recorded rest; durations are quantised to 2-bit codes.
module song_recorder
   import song_recorder_pkg::*;
#(
   parameter int TICK_CYCLES = 100000,
   parameter int DEPTH       = 64,
   parameter int ADDR_BITS   = 6,
   parameter int REST_MS     = 500,
   parameter int LEN_T1      = 250,
   parameter int LEN_T2      = 500,
   parameter int LEN_T3      = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 oct_up,
   input  logic                 oct_down,
   input  logic [6:0]           note_key,
   output logic                 wr_en,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [REC_W-1:0]     wr_data,
   output logic [ADDR_BITS:0]   rec_len,
   output logic                 recording,
   output logic                 full,
   output logic [1:0]           octave
);

   localparam logic [MS_W-1:0]    T1     = MS_W'(LEN_T1);
   localparam logic [MS_W-1:0]    T2     = MS_W'(LEN_T2);
   localparam logic [MS_W-1:0]    T3     = MS_W'(LEN_T3);
   localparam logic [MS_W-1:0]    T_REST = MS_W'(REST_MS);
   localparam logic [ADDR_BITS:0] CAP    = (ADDR_BITS+1)'(DEPTH);

   state_t r_state, r_after;
   state_t w_next, w_after;

   logic [ADDR_BITS:0]   r_rec_len;
   logic [1:0]           r_octave;
   logic                 r_wr_en;
   logic [ADDR_BITS-1:0] r_wr_addr;
   logic [REC_W-1:0]     r_wr_data;
   logic [2:0]           r_note, r_pend_note;
   logic [1:0]           r_hold_oct, r_pend_oct;

   logic [MS_W-1:0]  w_ms;
   logic [2:0]       w_key;
   logic             w_valid, w_rel, w_full;
   logic             w_wr, w_hold_new, w_pend, w_start, w_clr;
   logic [REC_W-1:0] w_rec;

   assign w_key   = key_note(note_key);
   assign w_valid = (w_key != NOTE_REST);
   assign w_rel   = (note_key == 7'd0);
   assign w_full  = (r_rec_len == CAP);

   always_comb begin
      w_next     = r_state;
      w_after    = r_after;
      w_wr       = 1'b0;
      w_rec      = '0;
      w_hold_new = 1'b0;
      w_pend     = 1'b0;
      w_start    = 1'b0;
      if (!en) begin
         w_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start && !stop) begin
                  w_next  = S_WAIT_KEY;
                  w_start = 1'b1;
               end
            end
            S_WAIT_KEY: begin
               if (stop || w_full) begin
                  w_next = S_DONE;
               end else if (w_valid) begin
                  if (r_rec_len != '0 && w_ms >= T_REST) begin
                     w_next  = S_COMMIT;
                     w_after = S_HOLD;
                     w_wr    = 1'b1;
                     w_pend  = 1'b1;
                     w_rec   = pack_rec(OCT_LOW, NOTE_REST,
                                        len_code(w_ms, T1, T2, T3));
                  end else begin
                     w_next     = S_HOLD;
                     w_hold_new = 1'b1;
                  end
               end
            end
            S_HOLD: begin
               w_rec = pack_rec(r_hold_oct, r_note,
                                len_code(w_ms, T1, T2, T3));
               if (stop) begin
                  w_next  = S_COMMIT;
                  w_after = S_DONE;
                  w_wr    = 1'b1;
               end else if (w_rel) begin
                  w_next  = S_COMMIT;
                  w_after = S_WAIT_KEY;
                  w_wr    = 1'b1;
               end else if (w_valid && w_key != r_note) begin
                  w_next  = S_COMMIT;
                  w_after = S_HOLD;
                  w_wr    = 1'b1;
                  w_pend  = 1'b1;
               end
            end
            S_COMMIT: begin
               w_next = (r_rec_len + 1'b1 == CAP) ? S_DONE : r_after;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Every entry into a timed state restarts the ms measurement.
   assign w_clr = (w_next != r_state) &&
                  (w_next == S_WAIT_KEY || w_next == S_HOLD);

   ms_ticker #(.TICK_CYCLES(TICK_CYCLES)) u_ms (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (w_clr),
      .o_ms  (w_ms)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_after     <= S_WAIT_KEY;
         r_rec_len   <= '0;
         r_octave    <= OCT_MID;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_note      <= NOTE_REST;
         r_hold_oct  <= OCT_MID;
         r_pend_note <= NOTE_REST;
         r_pend_oct  <= OCT_MID;
      end else begin
         r_state <= w_next;
         r_after <= w_after;
         r_wr_en <= w_wr;
         if (w_wr) begin
            r_wr_addr <= r_rec_len[ADDR_BITS-1:0];
            r_wr_data <= w_rec;
         end
         if (w_start) begin
            r_rec_len <= '0;
            r_octave  <= OCT_MID;
         end else begin
            if (r_state == S_COMMIT && en)
               r_rec_len <= r_rec_len + 1'b1;
            if (oct_up && !oct_down && r_octave != OCT_HIGH)
               r_octave <= r_octave + 2'd1;
            else if (oct_down && !oct_up && r_octave != OCT_LOW)
               r_octave <= r_octave - 2'd1;
         end
         if (w_hold_new) begin
            r_note     <= w_key;
            r_hold_oct <= r_octave;
         end
         if (w_pend) begin
            r_pend_note <= w_key;
            r_pend_oct  <= r_octave;
         end
         if (r_state == S_COMMIT && w_next == S_HOLD) begin
            r_note     <= r_pend_note;
            r_hold_oct <= r_pend_oct;
         end
      end
   end

   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign rec_len   = r_rec_len;
   assign octave    = r_octave;
   assign full      = w_full;
   assign recording = (r_state == S_WAIT_KEY) || (r_state == S_HOLD) ||
                      (r_state == S_COMMIT);

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder: 1 ms = 10 clocks, capacity 4 records.
// Writes are captured on the falling edge and checked against hand-built records.
module tb_song_recorder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       oct_up = 1'b0;
   logic       oct_down = 1'b0;
   logic [6:0] note_key = 7'd0;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [6:0] wr_data;
   logic [2:0] rec_len;
   logic       recording;
   logic       full;
   logic [1:0] octave;

   int total = 0;
   int bad = 0;

   logic [1:0] wa[$];
   logic [6:0] wd[$];

   song_recorder #(
      .TICK_CYCLES(10),
      .DEPTH(4),
      .ADDR_BITS(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .start     (start),
      .stop      (stop),
      .oct_up    (oct_up),
      .oct_down  (oct_down),
      .note_key  (note_key),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rec_len   (rec_len),
      .recording (recording),
      .full      (full),
      .octave    (octave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wa.push_back(wr_addr);
         wd.push_back(wr_data);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic pulse_up();
      oct_up = 1'b1; tick(); oct_up = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      total++;
      if (wr_en !== 1'b0) begin
         bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en);
      end
      total++;
      if (rec_len !== 3'd0) begin
         bad++; $display("FAIL reset_rec_len got=%0d want=0", rec_len);
      end
      total++;
      if (octave !== 2'd1) begin
         bad++; $display("FAIL reset_octave got=%0d want=1", octave);
      end
      total++;
      if (recording !== 1'b0) begin
         bad++; $display("FAIL reset_recording got=%b want=0", recording);
      end
   endtask

   task automatic test_single_note();
      int k;
      wa.delete(); wd.delete();
      pulse_start();
      total++;
      if (recording !== 1'b1) begin
         bad++; $display("FAIL single_recording got=%b want=1", recording);
      end
      note_key = 7'b0000100;
      tick(3000);
      note_key = 7'd0;
      k = 0;
      while (wr_en !== 1'b1 && k < 5) begin
         tick(); k++;
      end
      total++;
      if (wr_en !== 1'b1) begin
         bad++; $display("FAIL single_wr got=%b want=1", wr_en);
      end
      total++;
      if (wr_addr !== 2'd0 || wr_data !== 7'b0101101) begin
         bad++;
         $display("FAIL single_rec got=%0d/%b want=0/0101101",
                  wr_addr, wr_data);
      end
      total++;
      if (rec_len !== 3'd0) begin
         bad++; $display("FAIL single_len_during got=%0d want=0", rec_len);
      end
      tick();
      total++;
      if (rec_len !== 3'd1 || wr_en !== 1'b0) begin
         bad++;
         $display("FAIL single_len_after got=%0d/%b want=1/0", rec_len, wr_en);
      end
      tick(3);
      total++;
      if (wd.size() !== 1) begin
         bad++; $display("FAIL single_count got=%0d want=1", wd.size());
      end
   endtask

   task automatic test_rest();
      wa.delete(); wd.delete();
      tick(6000);
      note_key = 7'b0000001;
      tick(12000);
      note_key = 7'd0;
      for (int i = 0; i < 10 && wd.size() < 2; i++) tick();
      tick(2);
      total++;
      if (wd.size() !== 2) begin
         bad++; $display("FAIL rest_count got=%0d want=2", wd.size());
      end else begin
         total++;
         if (wa[0] !== 2'd1 || wd[0] !== 7'b0000010) begin
            bad++;
            $display("FAIL rest_rec got=%0d/%b want=1/0000010", wa[0], wd[0]);
         end
         total++;
         if (wa[1] !== 2'd2 || wd[1] !== 7'b0100111) begin
            bad++;
            $display("FAIL rest_note got=%0d/%b want=2/0100111", wa[1], wd[1]);
         end
      end
      total++;
      if (rec_len !== 3'd3) begin
         bad++; $display("FAIL rest_len got=%0d want=3", rec_len);
      end
   endtask

   task automatic test_octave();
      pulse_stop();
      tick(2);
      pulse_start();
      wa.delete(); wd.delete();
      pulse_up(); pulse_up(); pulse_up();
      total++;
      if (octave !== 2'd2) begin
         bad++; $display("FAIL oct_sat got=%0d want=2", octave);
      end
      oct_up = 1'b1; oct_down = 1'b1;
      tick();
      oct_up = 1'b0; oct_down = 1'b0;
      total++;
      if (octave !== 2'd2) begin
         bad++; $display("FAIL oct_both got=%0d want=2", octave);
      end
      note_key = 7'b0000010;
      tick(10);
      oct_down = 1'b1; tick(); oct_down = 1'b0;
      tick(40);
      note_key = 7'd0;
      tick(4);
      total++;
      if (octave !== 2'd1) begin
         bad++; $display("FAIL oct_down got=%0d want=1", octave);
      end
      total++;
      if (wd.size() !== 1) begin
         bad++; $display("FAIL oct_count got=%0d want=1", wd.size());
      end else begin
         total++;
         if (wa[0] !== 2'd0 || wd[0] !== 7'b1001000) begin
            bad++;
            $display("FAIL oct_rec got=%0d/%b want=0/1001000", wa[0], wd[0]);
         end
      end
   endtask

   task automatic test_full();
      logic [6:0] keys[5];
      logic [6:0] exp[4];
      keys = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000};
      exp  = '{7'b0100100, 7'b0101000, 7'b0101100, 7'b0110000};
      pulse_stop();
      tick(2);
      pulse_start();
      wa.delete(); wd.delete();
      for (int i = 0; i < 5; i++) begin
         note_key = keys[i];
         tick(30);
         note_key = 7'd0;
         tick(30);
      end
      total++;
      if (wd.size() !== 4) begin
         bad++; $display("FAIL full_count got=%0d want=4", wd.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (wa[i] !== 2'(i) || wd[i] !== exp[i]) begin
               bad++;
               $display("FAIL full_rec%0d got=%0d/%b want=%0d/%b",
                        i, wa[i], wd[i], i, exp[i]);
            end
         end
      end
      total++;
      if (full !== 1'b1 || recording !== 1'b0 || rec_len !== 3'd4) begin
         bad++;
         $display("FAIL full_state got=%b/%b/%0d want=1/0/4",
                  full, recording, rec_len);
      end
      pulse_start();
      total++;
      if (rec_len !== 3'd0 || full !== 1'b0 || recording !== 1'b1) begin
         bad++;
         $display("FAIL full_restart got=%0d/%b/%b want=0/0/1",
                  rec_len, full, recording);
      end
   endtask

   task automatic test_stop_abort();
      wa.delete(); wd.delete();
      note_key = 7'b0001000;
      tick(40);
      pulse_stop();
      total++;
      if (wr_en !== 1'b1 || recording !== 1'b1) begin
         bad++;
         $display("FAIL stop_commit got=%b/%b want=1/1", wr_en, recording);
      end
      tick();
      total++;
      if (recording !== 1'b0 || rec_len !== 3'd1) begin
         bad++;
         $display("FAIL stop_done got=%b/%0d want=0/1", recording, rec_len);
      end
      note_key = 7'd0;
      tick(5);
      total++;
      if (wd.size() !== 1) begin
         bad++; $display("FAIL stop_count got=%0d want=1", wd.size());
      end else begin
         total++;
         if (wa[0] !== 2'd0 || wd[0] !== 7'b0110000) begin
            bad++;
            $display("FAIL stop_rec got=%0d/%b want=0/0110000", wa[0], wd[0]);
         end
      end
   endtask

   task automatic test_en_drop();
      pulse_start();
      wa.delete(); wd.delete();
      note_key = 7'b0000001;
      tick(30);
      note_key = 7'd0;
      tick(30);
      pulse_up();
      note_key = 7'b0000010;
      tick(30);
      en = 1'b0;
      tick(3);
      total++;
      if (recording !== 1'b0 || rec_len !== 3'd1 || octave !== 2'd2) begin
         bad++;
         $display("FAIL en_drop got=%b/%0d/%0d want=0/1/2",
                  recording, rec_len, octave);
      end
      en = 1'b1;
      note_key = 7'd0;
      tick(5);
      total++;
      if (wd.size() !== 1 || recording !== 1'b0) begin
         bad++;
         $display("FAIL en_writes got=%0d/%b want=1/0", wd.size(), recording);
      end
   endtask

   initial begin
      test_reset();
      test_single_note();
      test_rest();
      test_octave();
      test_full();
      test_stop_abort();
      test_en_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
